// File: rtl/seq_alu.sv
// Handshaked sequential ALU: ADD/SUB/AND/OR/XOR/SHL/SHR/MUL with carry, zero and overflow flags.
// Define SEQ_ALU_MUL_EN to build the iterative multiplier; otherwise op 111 returns zero in one cycle.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

`ifdef SEQ_ALU_MUL_EN
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_sum;
`endif

    logic [WIDTH:0]   alu_w;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;
    logic [SHW-1:0]   sh;

    // Single-cycle datapath; shifts go through a WIDTH+1 window so the extra bit is the last bit shifted out
    always_comb begin
        sh    = b[SHW-1:0];
        alu_w = '0;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            3'b000: begin
                alu_w = {1'b0, a} + {1'b0, b};
                alu_r = alu_w[WIDTH-1:0];
                alu_c = alu_w[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                alu_w = {1'b0, a} - {1'b0, b};
                alu_r = alu_w[WIDTH-1:0];
                alu_c = alu_w[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010: alu_r = a & b;
            3'b011: alu_r = a | b;
            3'b100: alu_r = a ^ b;
            3'b101: begin
                alu_w = {1'b0, a} << sh;
                alu_r = alu_w[WIDTH-1:0];
                alu_c = alu_w[WIDTH];
            end
            3'b110: begin
                alu_w = {a, 1'b0} >> sh;
                alu_r = alu_w[WIDTH:1];
                alu_c = alu_w[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
`ifdef SEQ_ALU_MUL_EN
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                    if (op == 3'b111) begin
                        state_d  = MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                    end else begin
`else
                    begin
`endif
                        state_d  = DONE;
                        result_d = alu_r;
                        zero_d   = (alu_r == '0);
                        carry_d  = alu_c;
                        ovf_d    = alu_v;
                    end
                end
            end
`ifdef SEQ_ALU_MUL_EN
            MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    result_d = acc_sum[WIDTH-1:0];
                    zero_d   = (acc_sum[WIDTH-1:0] == '0);
                    carry_d  = |acc_sum[2*WIDTH-1:WIDTH];
                    ovf_d    = |acc_sum[2*WIDTH-1:WIDTH];
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
`ifdef SEQ_ALU_MUL_EN
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
`ifdef SEQ_ALU_MUL_EN
    assign busy      = (state_q == MUL);
`else
    assign busy      = 1'b0;
`endif

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It registers operands and results, adds XOR, logical shifts and an iterative multiply, and produces carry, zero and signed-overflow flags. Valid/ready handshakes on both sides let it sit between the register-file read stage and writeback, with arbitrary backpressure.

## Interface
- `WIDTH`, default 8: operand/result width; power of two, minimum 4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width (localparam, not overridable).

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: reset, asynchronous, active-low. One clock domain only.
- `in_valid`, in, 1: operand bundle valid.
- `in_ready`, out, 1: block can accept; combinational, equals `state==IDLE`.
- `a`, in, WIDTH: first operand.
- `b`, in, WIDTH: second operand; for shifts, `b[SHW-1:0]` is the shift amount and upper bits are ignored.
- `op`, in, 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- `out_valid`, out, 1: result bundle valid.
- `out_ready`, in, 1: consumer accepts.
- `result`, out, WIDTH: registered result.
- `zero`, out, 1: `result==0`.
- `carry`, out, 1: carry, borrow or lost-bit flag (see Operation).
- `overflow`, out, 1: two's-complement overflow.
- `busy`, out, 1: high in MUL state.

## Operation
FSM states and transitions:
- IDLE -> DONE on accept of a non-MUL op.
- IDLE -> MUL on accept of MUL.
- MUL -> DONE when the iteration counter reaches WIDTH-1.
- DONE -> IDLE on `out_valid && out_ready`.

Handshake rules:
- Accept occurs when `in_valid && in_ready`. `a`, `b` and `op` are captured at accept; later input changes have no effect.
- `out_valid` is high exactly in DONE.
- `result` and the flags are stable while `out_valid` is high and not yet consumed.

Per-op results and flags (internal sum/difference is WIDTH+1 bits):
- ADD: `result = a+b`; `carry` = bit WIDTH of the sum; `overflow` = operands share a sign and the result sign differs.
- SUB: `result = a-b` (mod 2^WIDTH); `carry` = borrow (`a<b` unsigned); `overflow` = operand signs differ and the result sign differs from `a`.
- AND, OR, XOR: bitwise; `carry=0`, `overflow=0`.
- SHL, SHR: logical shift by `s = b[SHW-1:0]`. `carry` = last bit shifted out (`a[WIDTH-s]` for SHL, `a[s-1]` for SHR), or 0 if `s==0`. `overflow=0`.
- MUL: unsigned shift-add, one partial product per cycle over a 2·WIDTH accumulator. `result` = low WIDTH bits. `carry` = (high WIDTH bits != 0). `overflow = carry`.
- `zero` is computed from the registered `result` for all ops.

## Timing
- Reset values (asserted asynchronously):
  - state=IDLE
  - `in_ready=1` once `rst_n` deasserts
  - `out_valid=0`, `result=0`, `zero=0`, `carry=0`, `overflow=0`, `busy=0`
  - MUL counter and accumulator = 0
- Non-MUL latency: accept at edge N, so `out_valid=1` after edge N.
- MUL latency: accept at edge N, so `busy=1` after edge N and `out_valid=1` after edge N+WIDTH.
- Throughput: one op per 2 cycles at best, because `in_ready` is low in DONE. With `out_ready` tied high there are no back-to-back accepts.
- Backpressure: DONE persists indefinitely while `out_ready=0`; no new accept occurs.
- `in_valid` may be high during MUL or DONE; nothing is captured until IDLE.
- Reset mid-MUL or mid-DONE aborts the operation and discards the result; no `out_valid` pulse follows.
- Undefined `op` bits: not possible, since all 8 codes are defined.

## Configuration
- `SEQ_ALU_MUL_EN` defined: MUL is implemented as above.
- `SEQ_ALU_MUL_EN` undefined:
  - The MUL state, counter and accumulator are removed.
  - Op 111 is a 1-cycle op with `result=0`, `zero=1`, `carry=0`, `overflow=0`.
  - `busy` is tied to 0.

## Test plan
All scenarios use WIDTH=8.
- ADD `a=0xFF`, `b=0x01`, `out_ready=1` -> one cycle later `result=0x00`, `zero=1`, `carry=1`, `overflow=0`.
- ADD `0x7F+0x01` -> `result=0x80`, `overflow=1`, `carry=0`. SUB `0x03-0x05` -> `result=0xFE`, `carry=1`, `overflow=0`. SUB `0x80-0x01` -> `result=0x7F`, `overflow=1`.
- SHL `a=0x81`, `b=0x01` -> `result=0x02`, `carry=1`. SHR `a=0x81`, `b=0x09` (s=1) -> `result=0x40`, `carry=1`. SHL with `s=0` -> `result=a`, `carry=0`.
- MUL `0x10*0x10` with `SEQ_ALU_MUL_EN` -> `busy` for 8 cycles, `out_valid` after edge N+8, `result=0x00`, `carry=1`, `overflow=1`, `zero=1`. Without the macro -> `result=0`, latency 1, `busy=0`.
- Backpressure: `out_ready=0` for 5 cycles after an XOR `0xAA^0x0F` -> `result=0xA5` held stable and `in_ready=0` throughout. A competing `in_valid` is not accepted until the cycle after `out_ready` rises.
- Assert `rst_n=0` at cycle 3 of a MUL -> all outputs reset immediately, no `out_valid` afterwards, and a fresh ADD issued after reset completes normally.
